// File: rtl/lc3b_types.sv
// Shared LC-3b types: datapath word, multiplier FSM states, multiply iteration count.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } lc3b_mult_state;

  localparam int unsigned MULT_CYCLES = 16;

endpackage

// File: rtl/mult_unit.sv
// Iterative 16x16 shift-add multiplier: one partial product per cycle, fixed
// 16-cycle run, sign fix-up applied as the final product is registered.
module mult_unit
  import lc3b_types::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        is_signed,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] f,
  output logic [15:0] f_hi
);

  localparam logic [3:0] LAST_ITER = 4'(MULT_CYCLES - 1);

  lc3b_mult_state state;
  logic [3:0]     cnt;
  logic [31:0]    mcand;
  lc3b_word       mplier;
  logic [31:0]    acc;
  logic           neg;

  lc3b_word       a_mag;
  lc3b_word       b_mag;
  logic           neg_in;
  logic [31:0]    add_term;
  logic [31:0]    acc_sum;
  logic [31:0]    prod_fix;

  // Operand magnitudes at capture, this cycle's partial sum, and the signed result.
  always_comb begin
    a_mag    = (is_signed && a[15]) ? (~a + 16'd1) : a;
    b_mag    = (is_signed && b[15]) ? (~b + 16'd1) : b;
    neg_in   = is_signed & (a[15] ^ b[15]);
    add_term = mplier[0] ? mcand : 32'd0;
    acc_sum  = acc + add_term;
    prod_fix = neg ? (~acc_sum + 32'd1) : acc_sum;
  end

  // FSM, counter, shift-add datapath and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      mcand  <= 32'd0;
      mplier <= 16'd0;
      acc    <= 32'd0;
      neg    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      f      <= 16'd0;
      f_hi   <= 16'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state  <= RUN;
            busy   <= 1'b1;
            cnt    <= 4'd0;
            acc    <= 32'd0;
            mcand  <= {16'd0, a_mag};
            mplier <= b_mag;
            neg    <= neg_in;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc    <= acc_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 4'd1;
          if (cnt == LAST_ITER) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            f     <= prod_fix[15:0];
            f_hi  <= prod_fix[31:16];
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_unit.sv
// Self-checking bench for mult_unit: behavioural countdown model compared every
// cycle, plus directed literal products, latency, stall and reset scenarios.
module tb_mult_unit;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        is_signed;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] f;
  logic [15:0] f_hi;

  int checks;
  int failures;

  // Reference model state: cycles left in the current multiply, held result.
  int          m_left;
  logic        m_done;
  logic [31:0] m_res;
  logic [31:0] m_pending;

  mult_unit dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .f         (f),
    .f_hi      (f_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Full-precision product from plain integer arithmetic.
  function automatic logic [31:0] ref_prod(input logic s, input logic [15:0] x, input logic [15:0] y);
    longint p;
    if (s) p = longint'($signed(x)) * longint'($signed(y));
    else   p = longint'(x) * longint'(y);
    return p[31:0];
  endfunction

  // Model advance on each rising edge, then compare every output.
  always @(posedge clk) begin
    #1;
    if (!reset_n) begin
      m_left = 0;
      m_done = 1'b0;
      m_res  = 32'd0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      m_done = (m_left == 0);
      if (m_done) m_res = m_pending;
    end else begin
      m_done = 1'b0;
      if (start) begin
        m_left    = 16;
        m_pending = ref_prod(is_signed, a, b);
      end
    end
    check("cyc_busy", 32'(busy), 32'(m_left > 0));
    check("cyc_done", 32'(done), 32'(m_done));
    check("cyc_f",    32'(f),    32'(m_res[15:0]));
    check("cyc_f_hi", 32'(f_hi), 32'(m_res[31:16]));
  end

  // One isolated request; checks latency, busy length and literal result.
  task automatic directed(input string name, input logic s, input logic [15:0] x,
                          input logic [15:0] y, input logic [31:0] exp);
    int n;
    int nbusy;
    bit seen;
    @(negedge clk);
    start = 1'b1; is_signed = s; a = x; b = y;
    n = 0; nbusy = 0; seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      start = 1'b0;
      n++;
      if (busy) nbusy++;
      if (done) seen = 1;
    end
    check({name, "_latency"}, 32'(n), 32'd17);
    check({name, "_busy_cycles"}, 32'(nbusy), 32'd16);
    check({name, "_product"}, {f_hi, f}, exp);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && (busy || done); i++) @(negedge clk);
  endtask

  initial begin
    checks = 0; failures = 0;
    m_left = 0; m_done = 1'b0; m_res = 32'd0; m_pending = 32'd0;
    reset_n = 1'b0; start = 1'b0; is_signed = 1'b0; a = 16'd0; b = 16'd0;

    // Outputs held low while reset is asserted, before any clock edge.
    #1;
    check("reset_outputs", {14'd0, busy, done, f_hi, f}, 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Pin the reference model on known products.
    check("model_s_fffe_x3", ref_prod(1'b1, 16'hFFFE, 16'h0003), 32'hFFFF_FFFA);
    check("model_u_ffff_sq", ref_prod(1'b0, 16'hFFFF, 16'hFFFF), 32'hFFFE_0001);

    // Directed literal results.
    directed("u_3x5",       1'b0, 16'h0003, 16'h0005, 32'h0000_000F);
    directed("u_ffffxffff", 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001);
    directed("s_fffex3",    1'b1, 16'hFFFE, 16'h0003, 32'hFFFF_FFFA);
    directed("s_8000x8000", 1'b1, 16'h8000, 16'h8000, 32'h4000_0000);
    directed("s_8000x1",    1'b1, 16'h8000, 16'h0001, 32'hFFFF_8000);
    directed("u_zero",      1'b0, 16'h0000, 16'hBEEF, 32'h0000_0000);

    // Result held in IDLE with no start.
    repeat (4) @(negedge clk);
    check("hold_after_done", {f_hi, f}, 32'h0000_0000);

    // Start pulsed mid-run with new operands is ignored.
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; a = 16'h1234; b = 16'h0010;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1; a = 16'h7777; b = 16'h9999;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 30 && !done; i++) @(negedge clk);
    check("ignore_start_in_run", {f_hi, f}, 32'h0001_2340);
    wait_idle();

    // Start held through DONE: back-to-back, first result held until second.
    @(negedge clk);
    start = 1'b1; is_signed = 1'b1; a = 16'hFFFF; b = 16'h0007;
    @(negedge clk);
    a = 16'h0100; b = 16'h0100; is_signed = 1'b0;
    for (int i = 0; i < 30 && !done; i++) @(negedge clk);
    check("b2b_first", {f_hi, f}, 32'hFFFF_FFF9);
    @(negedge clk);
    check("b2b_busy_no_gap", 32'(busy), 32'd1);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("b2b_first_held", {f_hi, f}, 32'hFFFF_FFF9);
    for (int i = 0; i < 30 && !done; i++) @(negedge clk);
    check("b2b_second", {f_hi, f}, 32'h0001_0000);
    wait_idle();

    // Reset at RUN cycle 8 aborts without a done pulse.
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; a = 16'h00FF; b = 16'h00FF;
    @(negedge clk); start = 1'b0;
    repeat (7) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("abort_outputs_zero", {14'd0, busy, done, f_hi, f}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("abort_no_done", 32'(done), 32'd0);
    directed("post_reset", 1'b1, 16'hFF00, 16'h0100, 32'hFFFF_0000);

    // Randomized traffic with occasional corner operands.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      start     = ($urandom_range(0, 9) < 3);
      is_signed = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: a = 16'h8000;
        1: a = 16'hFFFF;
        2: a = 16'h0000;
        default: a = 16'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0: b = 16'h8000;
        1: b = 16'h7FFF;
        2: b = 16'h0001;
        default: b = 16'($urandom);
      endcase
    end
    @(negedge clk); start = 1'b0;
    repeat (20) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
